// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the layer load sequencer.
// State encodings, error codes and per-layer beat lookup.
package layer_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_ARM  = 3'd1;
  localparam state_t ST_LOAD = 3'd2;
  localparam state_t ST_DONE = 3'd3;
  localparam state_t ST_ERR  = 3'd4;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'b00;
  localparam err_code_t ERR_SHORT   = 2'b01;
  localparam err_code_t ERR_OVERRUN = 2'b10;
  localparam err_code_t ERR_TIMEOUT = 2'b11;

  function automatic int beats_for_layer(
    input logic [1:0] layer,
    input int         l0,
    input int         l1,
    input int         l2,
    input int         l3
  );
    int n;
    unique case (layer)
      2'd0: n = l0;
      2'd1: n = l1;
      2'd2: n = l2;
      default: n = l3;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/layer_load_sequencer_timer.sv
// Stall watchdog for the layer load sequencer.
// Built only when LAYER_SEQ_TIMEOUT_EN is defined.
module layer_seq_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  // Fires on the LIMIT-th consecutive stalled cycle.
  assign o_expired = i_run & ~i_clear & (r_cnt == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (!i_run || i_clear || o_expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/layer_load_sequencer.sv
// Loads one layer's parameters from the DMA stream into the layer buffer.
// Optional stall watchdog: define LAYER_SEQ_TIMEOUT_EN.
module layer_load_sequencer
  import layer_seq_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 12,
  parameter int LAYER_STRIDE = 1024,
  parameter int L0_BEATS     = 256,
  parameter int L1_BEATS     = 512,
  parameter int L2_BEATS     = 512,
  parameter int L3_BEATS     = 128,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_load_state,
  input  logic [1:0]        i_current_layer,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              o_buf_we,
  output logic [ADDR_W-1:0] o_buf_addr,
  output logic [DATA_W-1:0] o_buf_wdata,
  output logic              o_busy,
  output logic              o_last,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic              o_irq
);

  localparam int CNT_W = $clog2(LAYER_STRIDE + 1);

  state_t            r_state;
  logic              r_load_q;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_base;
  logic              r_err;
  err_code_t         r_code;
  logic              r_done_lat;
  logic              r_done;
  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic w_start;
  logic w_accept;
  logic w_final;
  logic w_timeout;
  int   w_base_full;

  assign w_start = i_load_state & ~r_load_q &
                   ((r_state == ST_IDLE) |
                    (r_state == ST_DONE) |
                    (r_state == ST_ERR));

  assign w_accept    = s_axis_tvalid & (r_state == ST_LOAD);
  assign w_final     = (r_cnt == r_n - 1'b1);
  assign w_base_full = int'(i_current_layer) * LAYER_STRIDE;

`ifdef LAYER_SEQ_TIMEOUT_EN
  layer_seq_timer #(
    .LIMIT     (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .i_run     (r_state == ST_LOAD),
    .i_clear   (w_accept),
    .o_expired (w_timeout)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_load_q   <= 1'b0;
      r_n        <= '0;
      r_cnt      <= '0;
      r_base     <= '0;
      r_err      <= 1'b0;
      r_code     <= ERR_NONE;
      r_done_lat <= 1'b0;
      r_done     <= 1'b0;
      r_last     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_load_q <= i_load_state;
      r_done   <= (r_state == ST_DONE);
      r_last   <= 1'b0;
      r_we     <= 1'b0;
      if (w_start) begin
        r_state    <= ST_ARM;
        r_n        <= CNT_W'(beats_for_layer(i_current_layer,
                       L0_BEATS, L1_BEATS, L2_BEATS, L3_BEATS));
        r_base     <= ADDR_W'(w_base_full);
        r_cnt      <= '0;
        r_err      <= 1'b0;
        r_code     <= ERR_NONE;
        r_done_lat <= 1'b0;
      end else begin
        case (r_state)
          ST_ARM: r_state <= ST_LOAD;
          ST_LOAD: begin
            if (w_accept) begin
              r_addr  <= r_base + ADDR_W'(r_cnt);
              r_wdata <= s_axis_tdata;
              // An overrun beat has no home in the region, so drop it.
              if (w_final && !s_axis_tlast) begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
                r_code  <= ERR_OVERRUN;
              end else if (w_final) begin
                r_we    <= 1'b1;
                r_last  <= 1'b1;
                r_state <= ST_DONE;
              end else if (s_axis_tlast) begin
                r_we    <= 1'b1;
                r_state <= ST_ERR;
                r_err   <= 1'b1;
                r_code  <= ERR_SHORT;
              end else begin
                r_we  <= 1'b1;
                r_cnt <= r_cnt + 1'b1;
              end
            end else if (w_timeout) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
              r_code  <= ERR_TIMEOUT;
            end
          end
          ST_DONE: begin
            r_done_lat <= 1'b1;
            r_state    <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign s_axis_tready = (r_state == ST_LOAD);
  assign o_busy        = (r_state == ST_ARM) | (r_state == ST_LOAD);
  assign o_buf_we      = r_we;
  assign o_buf_addr    = r_addr;
  assign o_buf_wdata   = r_wdata;
  assign o_last        = r_last;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_err_code    = r_code;
  assign o_irq         = r_done_lat | r_err;

endmodule

// File: tb/tb_layer_load_sequencer.sv
// Bench for layer_load_sequencer: table of load scenarios plus
// hand-written timeout, reset and ignored-restart sequences.
module tb_layer_load_sequencer;

  logic        clk;
  logic        rstn;
  logic        i_load_state;
  logic [1:0]  i_current_layer;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        o_buf_we;
  logic [11:0] o_buf_addr;
  logic [31:0] o_buf_wdata;
  logic        o_busy;
  logic        o_last;
  logic        o_done;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic        o_irq;

  layer_load_sequencer dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_load_state    (i_load_state),
    .i_current_layer (i_current_layer),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .o_buf_we        (o_buf_we),
    .o_buf_addr      (o_buf_addr),
    .o_buf_wdata     (o_buf_wdata),
    .o_busy          (o_busy),
    .o_last          (o_last),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_err_code      (o_err_code),
    .o_irq           (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int         layer;
    int         n;
    int         tlast_at;
    int         nsend;
    bit         toggle;
    int         exp_wr;
    bit         exp_err;
    logic [1:0] exp_code;
    int         exp_done;
  } row_t;

  wr_t  exp_q[$];
  row_t rows[5];

  int npass = 0;
  int ntot  = 0;
  int n_wr  = 0;
  int n_last = 0;
  int n_done = 0;
  int cyc = 0;
  int last_cyc = 0;
  int done_cyc = 0;
  bit ph = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (o_buf_we) begin
      n_wr++;
      chk("wr_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(o_buf_addr), 64'(e.addr));
        chk("wr_data", 64'(o_buf_wdata), 64'(e.data));
      end
    end
    if (o_last) begin
      n_last++;
      last_cyc = cyc;
    end
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic start_pulse(input int layer);
    @(negedge clk);
    i_current_layer = 2'(layer);
    i_load_state = 1'b1;
    @(negedge clk);
    i_load_state = 1'b0;
  endtask

  task automatic drive_beat(input logic [11:0] base, input int idx,
                            input int n, input logic last,
                            input bit toggle, output bit ok);
    int guard;
    logic [31:0] d;
    guard = 0;
    ok = 1'b0;
    d = $urandom();
    while (!ok && guard < 64) begin
      @(negedge clk);
      s_axis_tvalid = toggle ? ph : 1'b1;
      ph = ~ph;
      s_axis_tdata = d;
      s_axis_tlast = last;
      #1;
      if (s_axis_tvalid && s_axis_tready && rstn) begin
        ok = 1'b1;
        if (!(idx == n - 1 && !last))
          exp_q.push_back('{addr: 12'(base + 12'(idx)), data: d});
      end
      guard++;
    end
  endtask

  initial begin
    bit ok;
    int wr0, last0, done0, k;
    logic [11:0] base;

    rows[0] = '{0, 256, 255, 256, 1'b0, 256, 1'b0, 2'b00, 1};
    rows[1] = '{2, 512, 511, 512, 1'b1, 512, 1'b0, 2'b00, 1};
    rows[2] = '{1, 512, 100, 101, 1'b0, 101, 1'b1, 2'b01, 0};
    rows[3] = '{3, 128, 999, 128, 1'b0, 127, 1'b1, 2'b10, 0};
    rows[4] = '{3, 128, 127, 128, 1'b1, 128, 1'b0, 2'b00, 1};

    rstn = 1'b0;
    i_load_state = 1'b0;
    i_current_layer = 2'd0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        64'({s_axis_tready, o_buf_we, o_buf_addr, o_buf_wdata, o_busy,
             o_last, o_done, o_err, o_err_code, o_irq}), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      base = 12'(rows[r].layer * 1024);
      wr0 = n_wr;
      last0 = n_last;
      done0 = n_done;
      start_pulse(rows[r].layer);
      chk($sformatf("arm_state_r%0d", r),
          64'({o_busy, s_axis_tready, o_err, o_irq}), 64'b1000);
      for (int b = 0; b < rows[r].nsend; b++) begin
        drive_beat(base, b, rows[r].n, logic'(b == rows[r].tlast_at),
                   rows[r].toggle, ok);
        if (!ok) begin
          chk($sformatf("beat_accept_r%0d_b%0d", r, b), 64'(ok), 64'd1);
          break;
        end
      end
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tlast = 1'b0;
      repeat (4) @(negedge clk);
      chk($sformatf("tready_low_r%0d", r), 64'(s_axis_tready), 64'd0);
      s_axis_tvalid = 1'b0;
      chk($sformatf("writes_r%0d", r), 64'(n_wr - wr0), 64'(rows[r].exp_wr));
      chk($sformatf("err_r%0d", r), 64'(o_err), 64'(rows[r].exp_err));
      chk($sformatf("code_r%0d", r), 64'(o_err_code), 64'(rows[r].exp_code));
      chk($sformatf("done_r%0d", r), 64'(n_done - done0), 64'(rows[r].exp_done));
      chk($sformatf("last_r%0d", r), 64'(n_last - last0), 64'(rows[r].exp_done));
      chk($sformatf("irq_r%0d", r), 64'(o_irq), 64'd1);
      chk($sformatf("busy_r%0d", r), 64'(o_busy), 64'd0);
      chk($sformatf("q_empty_r%0d", r), 64'(exp_q.size()), 64'd0);
      if (rows[r].exp_done == 1)
        chk($sformatf("last_to_done_r%0d", r), 64'(done_cyc - last_cyc), 64'd1);
    end

    // Stall after 10 beats
    start_pulse(0);
    for (int b = 0; b < 10; b++) begin
      drive_beat(12'd0, b, 256, 1'b0, 1'b0, ok);
      if (!ok) begin
        chk("stall_beat_accept", 64'(ok), 64'd1);
        break;
      end
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
    k = 0;
    while (!o_err && k < 1200) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_err", 64'(o_err), 64'd1);
    chk("timeout_code", 64'(o_err_code), 64'd3);
    chk("timeout_not_early", 64'(k >= 1000), 64'd1);
    chk("timeout_tready", 64'(s_axis_tready), 64'd0);
`else
    k = 0;
    repeat (5000) @(negedge clk);
    chk("no_timeout_busy", 64'({o_busy, o_err, o_err_code}), 64'b1000);
`endif
    chk("stall_q_empty", 64'(exp_q.size()), 64'd0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Ignored restart while busy, then reset at beat 50
    wr0 = n_wr;
    start_pulse(1);
    for (int b = 0; b < 50; b++) begin
      if (b == 20) i_load_state = 1'b1;
      if (b == 22) begin
        i_current_layer = 2'd3;
        i_load_state = 1'b0;
      end
      if (b == 24) i_load_state = 1'b1;
      drive_beat(12'd1024, b, 512, 1'b0, 1'b0, ok);
      if (!ok) begin
        chk("rst_seq_beat_accept", 64'(ok), 64'd1);
        break;
      end
    end
    chk("restart_ignored_busy", 64'({o_busy, s_axis_tready}), 64'b11);
    @(negedge clk);
    i_load_state = 1'b0;
    rstn = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst_mid_outs",
        64'({s_axis_tready, o_buf_we, o_buf_addr, o_buf_wdata, o_busy,
             o_last, o_done, o_err, o_err_code, o_irq}), 64'd0);
    rstn = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_writes", 64'(n_wr - wr0), 64'd50);
    chk("rst_mid_idle", 64'({o_busy, o_buf_we}), 64'd0);
    chk("rst_mid_q_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
